// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the EX operand stage.
// Holds the ALU op encodings, the operand-source select encodings, the
// layout of the registered E-stage state and a small helper function.
package ex_operand_stage_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_COPY2 = 4'd10
    } aluOpT;

    typedef enum logic [1:0] {
        SRC1_REG  = 2'b00,
        SRC1_PC   = 2'b01,
        SRC1_ZERO = 2'b10
    } aluSrc1T;

    typedef enum logic [1:0] {
        SRC2_REG   = 2'b00,
        SRC2_SHAMT = 2'b01,
        SRC2_IMM   = 2'b10
    } aluSrc2T;

    // Everything latched from ID into EX; an all-zero value is a NOP.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] regOut1;
        logic [XLEN-1:0] regOut2;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [3:0]      aluContrl;
        logic [1:0]      aluSrc1;
        logic [1:0]      aluSrc2;
        logic            regWrite;
    } eStateT;

    // Shift amounts ride in the rs2 index field and are zero-extended.
    function automatic logic [XLEN-1:0] shamtExt(input logic [REGW-1:0] idx);
        return {{(XLEN-REGW){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Forwarding selector for one source register of the EX stage.
// Compile-time option: EX_FORWARD_EN. When defined, the MEM result wins
// over the WB result, and register x0 never takes forwarded data. When not
// defined, the registered read value passes straight through and the hazard
// unit stalls instead.
module fwd_mux
    import ex_operand_stage_pkg::*;
(
    input  logic [REGW-1:0] i_rs,
    input  logic [XLEN-1:0] i_regVal,
    input  logic [XLEN-1:0] i_aluOutM,
    input  logic [REGW-1:0] i_rdM,
    input  logic            i_regWriteM,
    input  logic [XLEN-1:0] i_regWriteDataW,
    input  logic [REGW-1:0] i_rdW,
    input  logic            i_regWriteW,
    output logic [XLEN-1:0] o_fwd
);

`ifdef EX_FORWARD_EN
    logic w_hitM;
    logic w_hitW;

    assign w_hitM = i_regWriteM && (i_rdM != '0) && (i_rdM == i_rs);
    assign w_hitW = i_regWriteW && (i_rdW != '0) && (i_rdW == i_rs);

    // Pick the youngest in-flight producer of this register, else the file read.
    always_comb begin
        o_fwd = i_regVal;
        if (w_hitM) begin
            o_fwd = i_aluOutM;
        end else if (w_hitW) begin
            o_fwd = i_regWriteDataW;
        end
    end
`else
    logic w_unused;

    assign w_unused = ^{i_rs, i_aluOutM, i_rdM, i_regWriteM,
                        i_regWriteDataW, i_rdW, i_regWriteW};
    assign o_fwd    = i_regVal;
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// EX operand stage: ID/EX pipeline register plus operand selection.
// Compile-time option: EX_FORWARD_EN enables MEM/WB forwarding inside
// the two fwd_mux instances; without it the M/W ports are ignored.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            bubbleE,
    input  logic            flushE,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] RegOut1D,
    input  logic [XLEN-1:0] RegOut2D,
    input  logic [XLEN-1:0] ImmD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic [3:0]      AluContrlD,
    input  logic [1:0]      AluSrc1D,
    input  logic [1:0]      AluSrc2D,
    input  logic            RegWriteD,
    input  logic [XLEN-1:0] AluOutM,
    input  logic [REGW-1:0] RdM,
    input  logic            RegWriteM,
    input  logic [XLEN-1:0] RegWriteDataW,
    input  logic [REGW-1:0] RdW,
    input  logic            RegWriteW,
    output logic [XLEN-1:0] Operand1,
    output logic [XLEN-1:0] Operand2,
    output logic [3:0]      AluContrlE,
    output logic [XLEN-1:0] StoreDataE,
    output logic [XLEN-1:0] PCE,
    output logic [REGW-1:0] RdE,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic            RegWriteE
);

    eStateT          r_e;
    logic [XLEN-1:0] w_fwd1;
    logic [XLEN-1:0] w_fwd2;

    // Pipeline register: reset beats hold, hold beats flush, flush loads a NOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e <= '0;
        end else if (!bubbleE) begin
            if (flushE) begin
                r_e <= '0;
            end else begin
                r_e <= '{pc: PCD, regOut1: RegOut1D, regOut2: RegOut2D,
                         imm: ImmD, rs1: Rs1D, rs2: Rs2D, rd: RdD,
                         aluContrl: AluContrlD, aluSrc1: AluSrc1D,
                         aluSrc2: AluSrc2D, regWrite: RegWriteD};
            end
        end
    end

    fwd_mux u_fwd1 (
        .i_rs            (r_e.rs1),
        .i_regVal        (r_e.regOut1),
        .i_aluOutM       (AluOutM),
        .i_rdM           (RdM),
        .i_regWriteM     (RegWriteM),
        .i_regWriteDataW (RegWriteDataW),
        .i_rdW           (RdW),
        .i_regWriteW     (RegWriteW),
        .o_fwd           (w_fwd1)
    );

    fwd_mux u_fwd2 (
        .i_rs            (r_e.rs2),
        .i_regVal        (r_e.regOut2),
        .i_aluOutM       (AluOutM),
        .i_rdM           (RdM),
        .i_regWriteM     (RegWriteM),
        .i_regWriteDataW (RegWriteDataW),
        .i_rdW           (RdW),
        .i_regWriteW     (RegWriteW),
        .o_fwd           (w_fwd2)
    );

    // First ALU operand: register, PC (AUIPC) or zero (LUI / reserved).
    always_comb begin
        Operand1 = '0;
        case (r_e.aluSrc1)
            SRC1_REG:  Operand1 = w_fwd1;
            SRC1_PC:   Operand1 = r_e.pc;
            default:   Operand1 = '0;
        endcase
    end

    // Second ALU operand: register, shift amount, immediate or zero (reserved).
    always_comb begin
        Operand2 = '0;
        case (r_e.aluSrc2)
            SRC2_REG:   Operand2 = w_fwd2;
            SRC2_SHAMT: Operand2 = shamtExt(r_e.rs2);
            SRC2_IMM:   Operand2 = r_e.imm;
            default:    Operand2 = '0;
        endcase
    end

    assign StoreDataE = w_fwd2;
    assign AluContrlE = r_e.aluContrl;
    assign PCE        = r_e.pc;
    assign RdE        = r_e.rd;
    assign Rs1E       = r_e.rs1;
    assign Rs2E       = r_e.rs2;
    assign RegWriteE  = r_e.regWrite;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage.
// Expected forwarding results follow EX_FORWARD_EN when it is defined.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, bubbleE, flushE;
    logic [31:0] PCD, RegOut1D, RegOut2D, ImmD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [3:0]  AluContrlD;
    logic [1:0]  AluSrc1D, AluSrc2D;
    logic        RegWriteD;
    logic [31:0] AluOutM;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic [31:0] RegWriteDataW;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [31:0] Operand1, Operand2, StoreDataE, PCE;
    logic [3:0]  AluContrlE;
    logic [4:0]  RdE, Rs1E, Rs2E;
    logic        RegWriteE;

    int checkCount = 0;
    int errorCount = 0;

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .bubbleE(bubbleE), .flushE(flushE),
        .PCD(PCD), .RegOut1D(RegOut1D), .RegOut2D(RegOut2D), .ImmD(ImmD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .AluContrlD(AluContrlD), .AluSrc1D(AluSrc1D), .AluSrc2D(AluSrc2D),
        .RegWriteD(RegWriteD),
        .AluOutM(AluOutM), .RdM(RdM), .RegWriteM(RegWriteM),
        .RegWriteDataW(RegWriteDataW), .RdW(RdW), .RegWriteW(RegWriteW),
        .Operand1(Operand1), .Operand2(Operand2), .AluContrlE(AluContrlE),
        .StoreDataE(StoreDataE), .PCE(PCE), .RdE(RdE), .Rs1E(Rs1E),
        .Rs2E(Rs2E), .RegWriteE(RegWriteE)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Drive the pipeline controls, take one rising edge, settle 1 ns past it.
    task automatic applyStimulus(input logic rstV, input logic bubV, input logic flushV);
        rst     = rstV;
        bubbleE = bubV;
        flushE  = flushV;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: count it and report any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearMW();
        AluOutM = '0; RdM = '0; RegWriteM = 1'b0;
        RegWriteDataW = '0; RdW = '0; RegWriteW = 1'b0;
        #1;
    endtask

    initial begin
        // Junk on the D side while reset is held proves reset zeroes everything.
        PCD = 32'hDEAD_BEEF; RegOut1D = 32'h1111_1111; RegOut2D = 32'h2222_2222;
        ImmD = 32'h3333_3333; Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3;
        AluContrlD = ALU_SUB; AluSrc1D = SRC1_PC; AluSrc2D = SRC2_IMM; RegWriteD = 1'b1;
        AluOutM = '0; RdM = '0; RegWriteM = 1'b0;
        RegWriteDataW = '0; RdW = '0; RegWriteW = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rst_op1",   Operand1, 32'h0);
        checkOutput("rst_op2",   Operand2, 32'h0);
        checkOutput("rst_alu",   {28'h0, AluContrlE}, 32'h0);
        checkOutput("rst_rw",    {31'h0, RegWriteE}, 32'h0);
        checkOutput("rst_pc",    PCE, 32'h0);
        checkOutput("rst_store", StoreDataE, 32'h0);
        checkOutput("rst_rd",    {27'h0, RdE}, 32'h0);

        // ADD x7, x5, x6 with producers of x5 in both MEM and WB.
        PCD = 32'h20; RegOut1D = 32'h777; RegOut2D = 32'h22; ImmD = 32'h0;
        Rs1D = 5'd5; Rs2D = 5'd6; RdD = 5'd7; AluContrlD = ALU_ADD;
        AluSrc1D = SRC1_REG; AluSrc2D = SRC2_REG; RegWriteD = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("add_pc",   PCE, 32'h20);
        checkOutput("add_rd",   {27'h0, RdE}, 32'd7);
        checkOutput("add_rs1",  {27'h0, Rs1E}, 32'd5);
        checkOutput("add_rw",   {31'h0, RegWriteE}, 32'd1);
        checkOutput("add_alu",  {28'h0, AluContrlE}, 32'(ALU_ADD));
        checkOutput("add_nofwd_op1", Operand1, 32'h777);
        AluOutM = 32'h1234; RdM = 5'd5; RegWriteM = 1'b1;
        RegWriteDataW = 32'hFFFF; RdW = 5'd5; RegWriteW = 1'b1;
        #1;
        checkOutput("fwdM_op1", Operand1, FWD ? 32'h1234 : 32'h777);
        checkOutput("fwdM_op2", Operand2, 32'h22);
        // WB-only producer: x5 from WB, then x6 from WB.
        RegWriteM = 1'b0;
        #1;
        checkOutput("fwdW_op1", Operand1, FWD ? 32'hFFFF : 32'h777);
        RdW = 5'd6;
        #1;
        checkOutput("fwdW_op1_miss", Operand1, 32'h777);
        checkOutput("fwdW_op2",   Operand2, FWD ? 32'hFFFF : 32'h22);
        checkOutput("fwdW_store", StoreDataE, FWD ? 32'hFFFF : 32'h22);
        clearMW();

        // x0 as rs2 never takes forwarded data.
        Rs2D = 5'd0; RegOut2D = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        AluOutM = 32'h55; RdM = 5'd0; RegWriteM = 1'b1;
        RegWriteDataW = 32'hFFFF; RdW = 5'd0; RegWriteW = 1'b1;
        #1;
        checkOutput("x0_op2",   Operand2, 32'h0);
        checkOutput("x0_store", StoreDataE, 32'h0);
        clearMW();

        // Shift amount: Operand2 is the rs2 field, store data stays the register.
        AluSrc2D = SRC2_SHAMT; Rs2D = 5'd13; RegOut2D = 32'h99;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("shamt_op2",   Operand2, 32'd13);
        checkOutput("shamt_store", StoreDataE, 32'h99);

        // Bubble wins over flush and holds every register.
        PCD = 32'h100; RdD = 5'd9; RegWriteD = 1'b1; AluSrc2D = SRC2_REG;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("load_pc", PCE, 32'h100);
        PCD = 32'h200; RdD = 5'd4; RegWriteD = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("hold_pc", PCE, 32'h100);
        checkOutput("hold_rw", {31'h0, RegWriteE}, 32'd1);
        checkOutput("hold_rd", {27'h0, RdE}, 32'd9);

        // Reset during a hold clears state, then normal loading resumes.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("rsthold_pc", PCE, 32'h0);
        checkOutput("rsthold_rw", {31'h0, RegWriteE}, 32'h0);
        PCD = 32'h300; RegWriteD = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("resume_pc", PCE, 32'h300);

        // Flush inserts a NOP.
        RdD = 5'd3; RegOut1D = 32'h44; AluSrc1D = SRC1_REG; AluContrlD = ALU_OR;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("preflush_op1", Operand1, 32'h44);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("flush_rw",  {31'h0, RegWriteE}, 32'h0);
        checkOutput("flush_rd",  {27'h0, RdE}, 32'h0);
        checkOutput("flush_op1", Operand1, 32'h0);
        checkOutput("flush_alu", {28'h0, AluContrlE}, 32'h0);
        checkOutput("flush_pc",  PCE, 32'h0);

        // LUI then AUIPC, then the reserved select codes.
        AluSrc1D = SRC1_ZERO; AluSrc2D = SRC2_IMM; ImmD = 32'hABCDE000;
        RegOut1D = 32'h77; PCD = 32'h40;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("lui_op1", Operand1, 32'h0);
        checkOutput("lui_op2", Operand2, 32'hABCDE000);
        AluSrc1D = SRC1_PC;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("auipc_op1", Operand1, 32'h40);
        checkOutput("auipc_op2", Operand2, 32'hABCDE000);
        AluSrc1D = 2'b11; AluSrc2D = 2'b11; RegOut2D = 32'h5A;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rsvd_op1",   Operand1, 32'h0);
        checkOutput("rsvd_op2",   Operand2, 32'h0);
        checkOutput("rsvd_store", StoreDataE, 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
